// File: rtl/spi_host_driver.sv
// SPI mode-0 host: one full-duplex NBITS transfer per val/rdy request, MSB first,
// with the captured miso word returned on a val/rdy response stream.
module spi_host_driver #(
  parameter int unsigned NBITS   = 34,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] send_msg,
  input  logic             send_val,
  output logic             send_rdy,
  output logic [NBITS-1:0] recv_msg,
  output logic             recv_val,
  input  logic             recv_rdy,
  output logic             cs,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic [BIT_W-1:0]   r_bit;
  logic [NBITS-1:0]   r_tx;
  logic [NBITS-1:0]   r_rx;
  logic               r_cs;
  logic               r_sclk;
  logic               r_mosi;
  logic               r_send_rdy;
  logic               r_recv_val;
  logic [NBITS-1:0]   r_recv_msg;
  logic               r_miso_s1;
  logic               r_miso_s2;

  logic               w_div_end;
  logic               w_send_hs;
  logic               w_last_bit;

  assign w_div_end  = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_send_hs  = send_val && r_send_rdy;
  assign w_last_bit = (r_bit == BIT_W'(NBITS));

  // Two-flop synchroniser for the asynchronous miso input
  always_ff @(posedge clk) begin
    if (reset) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  // Transfer sequencer; every pin and handshake output is a register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_cs       <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_send_rdy <= 1'b1;
      r_recv_val <= 1'b0;
      r_recv_msg <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_div <= '0;
          if (w_send_hs) begin
            r_tx       <= send_msg;
            r_rx       <= '0;
            r_bit      <= '0;
            r_cs       <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= send_msg[NBITS-1];
            r_send_rdy <= 1'b0;
            r_state    <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_sclk  <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        // High phase ends by sampling miso; low phase ends by raising sclk or leaving
        S_SHIFT: begin
          if (w_div_end) begin
            r_div <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
              r_rx   <= {r_rx[NBITS-2:0], r_miso_s2};
              r_tx   <= r_tx << 1;
              r_mosi <= r_tx[NBITS-2];
              r_bit  <= r_bit + BIT_W'(1);
            end else if (w_last_bit) begin
              r_state <= S_HOLD;
            end else begin
              r_sclk <= 1'b1;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        S_HOLD: begin
          if (w_div_end) begin
            r_div      <= '0;
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
            r_recv_val <= 1'b1;
            r_recv_msg <= r_rx;
            r_state    <= S_DONE;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        S_DONE: begin
          r_div <= '0;
          if (recv_rdy) begin
            r_recv_val <= 1'b0;
            r_state    <= S_GAP;
          end
        end

        // Enforces a minimum cs-high time before the next request is taken
        S_GAP: begin
          if (w_div_end) begin
            r_div      <= '0;
            r_send_rdy <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_div      <= '0;
          r_cs       <= 1'b1;
          r_sclk     <= 1'b0;
          r_mosi     <= 1'b0;
          r_send_rdy <= 1'b1;
          r_recv_val <= 1'b0;
        end
      endcase
    end
  end

  assign send_rdy = r_send_rdy;
  assign recv_msg = r_recv_msg;
  assign recv_val = r_recv_val;
  assign cs       = r_cs;
  assign sclk     = r_sclk;
  assign mosi     = r_mosi;

endmodule
